// File: rtl/axi_burst_seq_if.sv
// rtl/axi_burst_seq_if.sv - burst request and beat-address handshake bundle for axi_burst_seq
interface axi_burst_seq_if #(
    parameter int AW = 32
) ();
    logic          i_req_valid;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr;
    logic [7:0]    i_req_len;
    logic [2:0]    i_req_size;
    logic [1:0]    i_req_burst;
    logic          o_beat_valid;
    logic          i_beat_ready;
    logic [AW-1:0] o_beat_addr;
    logic          o_beat_last;
    logic [2:0]    o_beat_size;

    // Upstream side: skid buffer issuing requests and datapath consuming beats.
    modport master (
        output i_req_valid, i_req_addr, i_req_len, i_req_size, i_req_burst, i_beat_ready,
        input  o_req_ready, o_beat_valid, o_beat_addr, o_beat_last, o_beat_size
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_len, i_req_size, i_req_burst, i_beat_ready,
        output o_req_ready, o_beat_valid, o_beat_addr, o_beat_last, o_beat_size
    );
endinterface

// File: rtl/axi_burst_seq.sv
// rtl/axi_burst_seq.sv - AXI4 FIXED/INCR/WRAP beat address sequencer confined to a 4kB page
module axi_burst_seq #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    axi_burst_seq_if.slave bus
);
    localparam int         DSZ   = $clog2(DW) - 3;
    localparam int         IN_AW = (AW < 12) ? AW : 12;
    localparam logic [2:0] DSZ_L = 3'(DSZ);
    localparam logic [AW-1:0] LOW_MASK = AW'({IN_AW{1'b1}});

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [AW-1:0]    addr_q, next_addr;
    logic [7:0]       count_q, len_q;
    logic [2:0]       size_q, req_eff;
    logic [1:0]       burst_q;
    logic             last_q;
    logic             beat_valid, req_ready, req_hs, beat_hs, wrap_len;
    logic [IN_AW-1:0] incr, aligned_lo, sum_lo, wrap_mask;

    assign beat_valid = (state == BUSY);
    assign req_ready  = !beat_valid || (last_q && bus.i_beat_ready);
    assign req_hs     = bus.i_req_valid && req_ready;
    assign beat_hs    = beat_valid && bus.i_beat_ready;
    assign req_eff    = (bus.i_req_size > DSZ_L) ? DSZ_L : bus.i_req_size;

    assign bus.o_req_ready  = req_ready;
    assign bus.o_beat_valid = beat_valid;
    assign bus.o_beat_addr  = addr_q;
    assign bus.o_beat_last  = last_q;
    assign bus.o_beat_size  = size_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_next;
    end

    // A last-beat handshake that coincides with a new request stays BUSY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_hs) state_next = BUSY;
            BUSY:    if (beat_hs && last_q && !req_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        incr = IN_AW'(1);
        case (size_q)
            3'd0:    incr = IN_AW'(1);
            3'd1:    incr = IN_AW'(2);
            3'd2:    incr = IN_AW'(4);
            3'd3:    incr = IN_AW'(8);
            3'd4:    incr = IN_AW'(16);
            3'd5:    incr = IN_AW'(32);
            3'd6:    incr = IN_AW'(64);
            3'd7:    incr = IN_AW'(128);
            default: incr = IN_AW'(1);
        endcase
    end

    assign aligned_lo = addr_q[IN_AW-1:0] & ~(incr - IN_AW'(1));
    assign sum_lo     = aligned_lo + incr;
    assign wrap_mask  = ((IN_AW'(len_q) + IN_AW'(1)) << size_q) - IN_AW'(1);
    assign wrap_len   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);

    // Only the in-page bits move; the carry out of the page is dropped by sum_lo's width.
    always_comb begin
        next_addr = (addr_q & ~LOW_MASK) | AW'(sum_lo);
        if (burst_q == 2'b00)
            next_addr = addr_q;
        else if (burst_q == 2'b10 && wrap_len)
            next_addr = (addr_q & ~AW'(wrap_mask)) | AW'(sum_lo & wrap_mask);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
        end else if (req_hs) begin
            addr_q  <= bus.i_req_addr;
            count_q <= '0;
            len_q   <= bus.i_req_len;
            size_q  <= req_eff;
            burst_q <= bus.i_req_burst;
            last_q  <= (bus.i_req_len == 8'd0);
        end else if (beat_hs) begin
            if (last_q) begin
                last_q <= 1'b0;
            end else begin
                addr_q  <= next_addr;
                count_q <= count_q + 8'd1;
                last_q  <= ((count_q + 8'd1) == len_q);
            end
        end
    end
endmodule
